// File: rtl/v_vram_arb.sv
// v_vram_arb
//   Two-port arbiter/sequencer for the single synchronous VRAM port.
//   Port 0 = vector memory unit, port 1 = host/DMA loader.
//   Round-robin on ties, locked bursts capped at MAX_BURST grants, registered
//   issue stage onto the VRAM pins, and a 2-deep tag pipe that steers each
//   read's return beat (two cycles after grant) to the requester that issued it.
// Ports
//   clk, rst                         clock, async active-high reset
//   reqN_i/weN_i/lockN_i             request valid / write / hold grant for next beat
//   addrN_i/wdataN_i/maskN_i         request payload
//   gntN_o                           combinational accept (transfer on req&gnt)
//   rvalidN_o/rdataN_o               read return (rdata is vram_dout_i on both)
//   vram_ren_o/vram_wen_o            registered one-cycle strobes
//   vram_addr_o/vram_din_o/vram_mask_o  registered payload (held when idle)
//   vram_dout_i                      synchronous VRAM read data
module v_vram_arb #(
   parameter int ADDR_W    = 64,
   parameter int DATA_W    = 512,
   parameter int MAX_BURST = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0_i,
   input  logic              we0_i,
   input  logic              lock0_i,
   input  logic [ADDR_W-1:0] addr0_i,
   input  logic [DATA_W-1:0] wdata0_i,
   input  logic [DATA_W-1:0] mask0_i,
   input  logic              req1_i,
   input  logic              we1_i,
   input  logic              lock1_i,
   input  logic [ADDR_W-1:0] addr1_i,
   input  logic [DATA_W-1:0] wdata1_i,
   input  logic [DATA_W-1:0] mask1_i,
   output logic              gnt0_o,
   output logic              gnt1_o,
   output logic              rvalid0_o,
   output logic              rvalid1_o,
   output logic [DATA_W-1:0] rdata0_o,
   output logic [DATA_W-1:0] rdata1_o,
   output logic              vram_ren_o,
   output logic              vram_wen_o,
   output logic [ADDR_W-1:0] vram_addr_o,
   output logic [DATA_W-1:0] vram_din_o,
   output logic [DATA_W-1:0] vram_mask_o,
   input  logic [DATA_W-1:0] vram_dout_i
);

   typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

   localparam int               CNT_W = $clog2(MAX_BURST + 1);
   localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_BURST);
   localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               last_q, last_d;
   logic               armed_q;
   logic               hold0, hold1;
   logic               gnt_any, we_w;

   logic               ren_q, wen_q;
   logic [ADDR_W-1:0]  addr_q;
   logic [DATA_W-1:0]  din_q, mask_q;
   logic [2:1]         tag_vld_q, tag_id_q;

   // An owner keeps the port only while its burst is below the cap; at the
   // cap the block arbitrates as if IDLE this very cycle (last_q already
   // names the owner), so a waiting peer is granted with no bubble.
   assign hold0 = (state_q == OWN0) && (cnt_q < MAX_C);
   assign hold1 = (state_q == OWN1) && (cnt_q < MAX_C);

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         last_q  <= 1'b1;
         armed_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         last_q  <= last_d;
         armed_q <= 1'b1;
      end
   end

   // Output (grant) logic. armed_q keeps grants off during reset and for the
   // cycle in which reset is released.
   always_comb begin
      gnt0_o = 1'b0;
      gnt1_o = 1'b0;
      if (!armed_q) begin
         gnt0_o = 1'b0;
      end else if (hold0) begin
         gnt0_o = req0_i;
      end else if (hold1) begin
         gnt1_o = req1_i;
      end else if (req0_i && req1_i) begin
         gnt0_o = last_q;
         gnt1_o = ~last_q;
      end else begin
         gnt0_o = req0_i;
         gnt1_o = req1_i;
      end
   end

   // Next-state logic: any cycle without a locked grant lands in IDLE,
   // which also covers owner release (req dropped) and the burst cap.
   always_comb begin
      state_d = IDLE;
      cnt_d   = '0;
      last_d  = last_q;
      if (gnt0_o) begin
         last_d = 1'b0;
         if (lock0_i) begin
            state_d = OWN0;
            cnt_d   = hold0 ? cnt_q + ONE_C : ONE_C;
         end
      end else if (gnt1_o) begin
         last_d = 1'b1;
         if (lock1_i) begin
            state_d = OWN1;
            cnt_d   = hold1 ? cnt_q + ONE_C : ONE_C;
         end
      end
   end

   assign gnt_any = gnt0_o | gnt1_o;
   assign we_w    = gnt1_o ? we1_i : we0_i;

   // Issue stage and read-return tag pipe
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ren_q     <= 1'b0;
         wen_q     <= 1'b0;
         addr_q    <= '0;
         din_q     <= '0;
         mask_q    <= '0;
         tag_vld_q <= '0;
         tag_id_q  <= '0;
      end else begin
         ren_q        <= gnt_any & ~we_w;
         wen_q        <= gnt_any & we_w;
         tag_vld_q[1] <= gnt_any & ~we_w;
         tag_id_q[1]  <= gnt1_o;
         tag_vld_q[2] <= tag_vld_q[1];
         tag_id_q[2]  <= tag_id_q[1];
         if (gnt_any) begin
            addr_q <= gnt1_o ? addr1_i  : addr0_i;
            din_q  <= gnt1_o ? wdata1_i : wdata0_i;
            mask_q <= gnt1_o ? mask1_i  : mask0_i;
         end
      end
   end

   assign vram_ren_o  = ren_q;
   assign vram_wen_o  = wen_q;
   assign vram_addr_o = addr_q;
   assign vram_din_o  = din_q;
   assign vram_mask_o = mask_q;
   assign rvalid0_o   = tag_vld_q[2] & ~tag_id_q[2];
   assign rvalid1_o   = tag_vld_q[2] &  tag_id_q[2];
   assign rdata0_o    = vram_dout_i;
   assign rdata1_o    = vram_dout_i;

endmodule

// File: tb/tb_v_vram_arb.sv
module tb_v_vram_arb;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         req0, we0, lock0, req1, we1, lock1;
   logic [63:0]  addr0, addr1;
   logic [511:0] wdata0, mask0, wdata1, mask1;
   logic         gnt0, gnt1, rvalid0, rvalid1, vram_ren, vram_wen;
   logic [511:0] rdata0, rdata1, vram_din, vram_mask, vram_dout;
   logic [63:0]  vram_addr;

   typedef struct {
      bit           port;
      logic [511:0] data;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   n_checks = 0;
   int   n_fail   = 0;

   always #5 clk = ~clk;

   v_vram_arb #(.ADDR_W(64), .DATA_W(512), .MAX_BURST(4)) dut (
      .clk(clk), .rst(rst),
      .req0_i(req0), .we0_i(we0), .lock0_i(lock0), .addr0_i(addr0),
      .wdata0_i(wdata0), .mask0_i(mask0),
      .req1_i(req1), .we1_i(we1), .lock1_i(lock1), .addr1_i(addr1),
      .wdata1_i(wdata1), .mask1_i(mask1),
      .gnt0_o(gnt0), .gnt1_o(gnt1), .rvalid0_o(rvalid0), .rvalid1_o(rvalid1),
      .rdata0_o(rdata0), .rdata1_o(rdata1),
      .vram_ren_o(vram_ren), .vram_wen_o(vram_wen), .vram_addr_o(vram_addr),
      .vram_din_o(vram_din), .vram_mask_o(vram_mask), .vram_dout_i(vram_dout)
   );

   function automatic logic [511:0] mem_word(input logic [63:0] a);
      return {8{a ^ 64'h0123_4567_89AB_CDEF}};
   endfunction

   // Synchronous VRAM model: data valid the cycle after the read strobe
   always @(posedge clk)
      if (vram_ren) vram_dout <= mem_word(vram_addr);

   // Scoreboard: every rvalid must match the oldest expected read
   always @(negedge clk) begin
      if (rvalid0 && rvalid1) begin
         n_checks++; n_fail++;
         $display("FAIL dual_rvalid: got rvalid0=1 rvalid1=1 expected at most one");
      end else if (rvalid0 || rvalid1) begin
         n_checks++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_rvalid: got rvalid on port %0d expected none", rvalid1);
         end else begin
            mon_e = exp_q.pop_front();
            if (rvalid1 !== mon_e.port || (rvalid1 ? rdata1 : rdata0) !== mon_e.data) begin
               n_fail++;
               $display("FAIL rdata_return: got port %0d data %h expected port %0d data %h",
                        rvalid1, (rvalid1 ? rdata1 : rdata0), mon_e.port, mon_e.data);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_rd(input bit p, input logic [63:0] a);
      exp_t e;
      e.port = p;
      e.data = mem_word(a);
      exp_q.push_back(e);
   endtask

   task automatic test_reset();
      req0 = 1'b1; req1 = 1'b1;
      @(negedge clk);
      n_checks++;
      if ({gnt0, gnt1, rvalid0, rvalid1, vram_ren, vram_wen} !== 6'b0) begin
         n_fail++;
         $display("FAIL reset_ctrl: got %b expected 000000",
                  {gnt0, gnt1, rvalid0, rvalid1, vram_ren, vram_wen});
      end
      n_checks++;
      if (vram_addr !== 64'h0 || vram_din !== 512'h0 || vram_mask !== 512'h0) begin
         n_fail++;
         $display("FAIL reset_data: got addr %h expected 0 (din/mask also 0)", vram_addr);
      end
      req0 = 1'b0; req1 = 1'b0;
      tick();
      rst = 1'b0;
      tick();
      tick();
   endtask

   task automatic test_single_read();
      req0 = 1'b1; we0 = 1'b0; addr0 = 64'h8100_0000;
      @(negedge clk);
      n_checks++;
      if ({gnt1, gnt0} !== 2'b01) begin
         n_fail++; $display("FAIL single_gnt: got %b expected 01", {gnt1, gnt0});
      end
      push_rd(1'b0, addr0);
      tick();
      req0 = 1'b0;
      @(negedge clk);
      n_checks++;
      if (vram_ren !== 1'b1 || vram_wen !== 1'b0 || vram_addr !== 64'h8100_0000) begin
         n_fail++;
         $display("FAIL single_issue: got ren %b wen %b addr %h expected 1 0 81000000",
                  vram_ren, vram_wen, vram_addr);
      end
      @(negedge clk);
      n_checks++;
      if (rvalid0 !== 1'b1 || rvalid1 !== 1'b0) begin
         n_fail++;
         $display("FAIL single_rvalid: got %b%b expected 10", rvalid0, rvalid1);
      end
      tick();
   endtask

   task automatic test_write();
      req1 = 1'b1; we1 = 1'b1; addr1 = 64'h40;
      wdata1 = 512'hDEAD_BEEF;
      mask1  = {448'h0, {64{1'b1}}};
      @(negedge clk);
      n_checks++;
      if ({gnt1, gnt0} !== 2'b10) begin
         n_fail++; $display("FAIL write_gnt: got %b expected 10", {gnt1, gnt0});
      end
      tick();
      req1 = 1'b0; we1 = 1'b0;
      @(negedge clk);
      n_checks++;
      if (vram_wen !== 1'b1 || vram_ren !== 1'b0 || vram_addr !== 64'h40) begin
         n_fail++;
         $display("FAIL write_strobe: got wen %b ren %b addr %h expected 1 0 40",
                  vram_wen, vram_ren, vram_addr);
      end
      n_checks++;
      if (vram_din !== 512'hDEAD_BEEF || vram_mask !== {448'h0, {64{1'b1}}}) begin
         n_fail++;
         $display("FAIL write_payload: got din %h mask %h", vram_din, vram_mask);
      end
      tick();
      @(negedge clk);
      n_checks++;
      if (rvalid0 !== 1'b0 || rvalid1 !== 1'b0) begin
         n_fail++; $display("FAIL write_no_rvalid: got %b%b expected 00", rvalid0, rvalid1);
      end
      tick();
   endtask

   task automatic test_round_robin();
      req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0;
      addr0 = 64'h1000; addr1 = 64'h2000;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         n_checks++;
         if ({gnt1, gnt0} !== ((i % 2) ? 2'b10 : 2'b01)) begin
            n_fail++;
            $display("FAIL rr_gnt[%0d]: got %b expected %b", i, {gnt1, gnt0},
                     ((i % 2) ? 2'b10 : 2'b01));
         end
         push_rd(bit'(i % 2), (i % 2) ? addr1 : addr0);
         tick();
      end
      req0 = 1'b0; req1 = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({rvalid1, rvalid0} !== 2'b01) begin
         n_fail++; $display("FAIL rr_rvalid_a: got %b expected 01", {rvalid1, rvalid0});
      end
      tick();
      @(negedge clk);
      n_checks++;
      if ({rvalid1, rvalid0} !== 2'b10) begin
         n_fail++; $display("FAIL rr_rvalid_b: got %b expected 10", {rvalid1, rvalid0});
      end
      tick();
   endtask

   task automatic test_lock_drop();
      bit exp_p[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
      int b0 = 0;
      int b1 = 0;
      for (int i = 0; i < 4; i++) begin
         req0 = (b0 < 3); lock0 = (b0 < 2); addr0 = 64'h3000 + 64'(b0) * 64'h40;
         req1 = (b1 < 1); lock1 = 1'b0;     addr1 = 64'h4000;
         @(negedge clk);
         n_checks++;
         if ({gnt1, gnt0} !== (exp_p[i] ? 2'b10 : 2'b01)) begin
            n_fail++;
            $display("FAIL lockdrop_gnt[%0d]: got %b expected %b", i, {gnt1, gnt0},
                     (exp_p[i] ? 2'b10 : 2'b01));
         end
         push_rd(exp_p[i], exp_p[i] ? addr1 : addr0);
         if (exp_p[i]) b1++; else b0++;
         tick();
      end
      req0 = 1'b0; req1 = 1'b0; lock0 = 1'b0;
      tick();
   endtask

   task automatic test_burst_limit();
      bit exp_p[8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
      int b0 = 0;
      int b1 = 0;
      // port 0 alone first so that port 1 wins the opening tie
      req0 = 1'b1; addr0 = 64'h5000;
      @(negedge clk);
      n_checks++;
      if ({gnt1, gnt0} !== 2'b01) begin
         n_fail++; $display("FAIL burst_pre_gnt: got %b expected 01", {gnt1, gnt0});
      end
      push_rd(1'b0, addr0);
      tick();
      for (int i = 0; i < 8; i++) begin
         req1 = (b1 < 6); lock1 = (b1 < 5); addr1 = 64'h6000 + 64'(b1) * 64'h40;
         req0 = (b0 < 2); lock0 = 1'b0;     addr0 = 64'h7000 + 64'(b0) * 64'h40;
         @(negedge clk);
         n_checks++;
         if ({gnt1, gnt0} !== (exp_p[i] ? 2'b10 : 2'b01)) begin
            n_fail++;
            $display("FAIL burst_gnt[%0d]: got %b expected %b", i, {gnt1, gnt0},
                     (exp_p[i] ? 2'b10 : 2'b01));
         end
         push_rd(exp_p[i], exp_p[i] ? addr1 : addr0);
         if (exp_p[i]) b1++; else b0++;
         tick();
      end
      req0 = 1'b0; req1 = 1'b0; lock1 = 1'b0;
      tick(); tick(); tick();
   endtask

   task automatic test_reset_midflight();
      req0 = 1'b1; req1 = 1'b1; addr0 = 64'h9000; addr1 = 64'hA000;
      @(negedge clk);
      n_checks++;
      if ({gnt1, gnt0} !== 2'b10) begin
         n_fail++; $display("FAIL mid_pre_gnt: got %b expected 10", {gnt1, gnt0});
      end
      tick();
      rst = 1'b1;
      #1;
      n_checks++;
      if ({vram_ren, vram_wen, gnt0, gnt1} !== 4'b0 || vram_addr !== 64'h0) begin
         n_fail++;
         $display("FAIL mid_async_rst: got ren/wen/gnt %b addr %h expected 0",
                  {vram_ren, vram_wen, gnt0, gnt1}, vram_addr);
      end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_checks++;
         if ({rvalid0, rvalid1, vram_ren, vram_wen} !== 4'b0 || vram_mask !== 512'h0) begin
            n_fail++;
            $display("FAIL mid_in_rst[%0d]: got %b expected 0000", i,
                     {rvalid0, rvalid1, vram_ren, vram_wen});
         end
         tick();
      end
      rst = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({gnt1, gnt0} !== 2'b00) begin
         n_fail++; $display("FAIL mid_release_gnt: got %b expected 00", {gnt1, gnt0});
      end
      tick();
      @(negedge clk);
      n_checks++;
      if ({gnt1, gnt0} !== 2'b01) begin
         n_fail++; $display("FAIL mid_first_tie: got %b expected 01", {gnt1, gnt0});
      end
      push_rd(1'b0, addr0);
      tick();
      req0 = 1'b0; req1 = 1'b0;
      tick(); tick(); tick();
   endtask

   task automatic test_drain();
      tick(); tick();
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++; $display("FAIL drain: got %0d pending reads expected 0", exp_q.size());
      end
   endtask

   initial begin
      req0 = 1'b0; we0 = 1'b0; lock0 = 1'b0; addr0 = '0; wdata0 = '0; mask0 = '0;
      req1 = 1'b0; we1 = 1'b0; lock1 = 1'b0; addr1 = '0; wdata1 = '0; mask1 = '0;
      test_reset();
      test_single_read();
      test_write();
      test_round_robin();
      test_lock_drop();
      test_burst_limit();
      test_reset_midflight();
      test_drain();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/v_vram_arb.md
# v_vram_arb

Two-port arbiter and sequencer for the single VRAM port. Requester 0 is the vector memory unit (VLE64/VSE64/VLX/VSX path); requester 1 is the host/DMA loader that preloads and drains vector data. The block grants the port round-robin, supports locked bursts with a bounded length, and registers the winning request onto the VRAM pins. It also routes synchronous read data back to the requester that issued it.

## Interface
- ADDR_W, 64, VRAM address width (matches `VRAM_ADDR_BUS`)
- DATA_W, 512, VRAM data/mask width (matches `VRAM_DATA_BUS`, = `VLEN`)
- MAX_BURST, 4, max consecutive locked grants to one requester (≥1)
- clk  in  1  clock; all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- reqN_i  in  1  request valid, N∈{0,1}
- weN_i  in  1  1=write, 0=read
- lockN_i  in  1  keep grant for next beat (burst)
- addrN_i  in  ADDR_W  request address
- wdataN_i  in  DATA_W  write data
- maskN_i  in  DATA_W  bit-level write mask
- gntN_o  out  1  request accepted this cycle (combinational)
- rvalidN_o  out  1  read data valid for requester N
- rdataN_o  out  DATA_W  read data (= vram_dout_i)
- vram_ren_o, vram_wen_o  out  1  registered VRAM strobes
- vram_addr_o  out  ADDR_W;  vram_din_o, vram_mask_o  out  DATA_W  registered

## Operation
- Handshake: request held stable until gntN_o=1. Transfer occurs in the cycle req&gnt. Writes have no further response. Reads return exactly one rvalidN_o pulse.
- At most one gnt per cycle. gnt0_o & gnt1_o is never 1.
- FSM states: IDLE, OWN0, OWN1.
  - IDLE: one requester → grant it. Both → grant the one ≠ last_gnt (reset last_gnt=1, so port 0 wins the first tie). Granted with lock=1 → OWNn, burst_cnt=1. Otherwise stay IDLE and update last_gnt.
  - OWNn: only port n can be granted; the other port waits regardless of req.
  - OWNn, reqn & lockn & burst_cnt<MAX_BURST → grant n, burst_cnt++.
  - OWNn, reqn & lockn=0 → grant n (final beat), go IDLE, last_gnt=n.
  - OWNn, burst_cnt==MAX_BURST → no grant to n. Go IDLE with last_gnt=n, so the other port wins the next tie. If the other port is not requesting, n may be re-granted from IDLE.
  - OWNn, reqn=0 → release to IDLE the same cycle, no grant. Arbitration restarts next cycle.
- MAX_BURST=1: lock never holds. OWNn always exits at the next check.
- Issue stage: on grant, register we/addr/wdata/mask of the winner into vram_*; vram_ren_o=~we, vram_wen_o=we for one cycle. No grant → ren=wen=0; addr/din/mask hold their previous value.
- Return: a 2-deep tag pipeline {valid, id} follows each read. rvalidN_o=1 two cycles after the granting cycle when id=N. rdataN_o = vram_dout_i is driven to both ports at all times; it is qualified only by rvalid.
- Back-to-back reads from either port give one rvalid per cycle, in issue order.

## Timing
- Cycle T: req&gnt (combinational from req, state, last_gnt).
- T+1: vram_ren_o/wen_o asserted. VRAM samples address.
- T+2: vram_dout_i valid; rvalidN_o=1.
- Throughput: one access per cycle, no bubbles while requests are present. Exception: a forced MAX_BURST release costs zero cycles when the other port is waiting, because the other port is granted from IDLE in the same cycle the FSM exits.
- Reset values: all gnt, rvalid, vram_ren_o, vram_wen_o = 0; vram_addr_o, vram_din_o, vram_mask_o = 0; FSM=IDLE; burst_cnt=0; last_gnt=1; tag pipeline empty.
- Reset mid-burst or with reads in flight: in-flight reads are discarded and no rvalid is produced after reset deasserts. Requesters reissue.
- Reset asserted asynchronously forces strobes low immediately. No VRAM access is issued in the cycle reset deasserts.

## Test plan
- Single read: req0 rd addr 0x8100_0000 at T → gnt0 at T; vram_ren_o=1 and addr=0x8100_0000 at T+1; rvalid0=1 with rdata=memory word at T+2; rvalid1 stays 0.
- Tie round-robin: both read-request continuously, no lock, for 4 cycles → grants 0,1,0,1. rvalid0/rvalid1 alternate starting at T+2.
- Locked burst limit: MAX_BURST=4, port 1 lock=1 for 6 beats, port 0 requesting throughout → gnt1 for 4 cycles, then gnt0, then gnt1 resumes. Port 0 is never granted during OWN1.
- Write path: req1 write, addr 0x40, mask low 64 bits set, data 0xDEAD_BEEF → vram_wen_o=1 with the same addr/din/mask at T+1; no rvalid.
- Lock drop: port 0 lock for 2 beats, then lock=0 on the 3rd → 3 grants, FSM returns to IDLE, and a pending port 1 is granted on the next cycle.
- Reset mid-flight: two reads issued, rst pulsed at T+1 → rvalid0/1 never assert. All outputs are 0 during reset. The first post-reset tie goes to port 0.
